signed_div_frontend: RTL and testbench

//  Signed front/back end for sequential_divider (unsigned, restoring, one quotient bit per cycle).
//  - Accepts one signed operand pair on a valid/ready handshake.
//  - Drives magnitudes into the divider and sequences its i_valid.
//  - Captures the quotient and re-applies the sign. Delivers a result with valid/ready and a divide-by-zero flag.
//  - Sits between the operand producer and the divider. The top level wires div_* to the divider instance.

---
 rtl/signed_div_pkg.sv | 28 ++
 rtl/signed_div_frontend_sign_fix.sv | 31 +++
 rtl/signed_div_frontend.sv | 155 +++++++++++++++
 tb/tb_signed_div_frontend.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/signed_div_pkg.sv
// Shared types and helpers for the signed divider front end.
// Helpers work on a wide word; callers sign- or zero-extend into it and
// take back the low DATA_WIDTH bits.
package signed_div_pkg;

  localparam int SDF_MAX_W = 64;

  typedef logic [SDF_MAX_W-1:0] sdf_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sdf_state_t;

  // Two's-complement negate; the low W bits equal the W-bit negation.
  function automatic sdf_word_t sdf_neg(input sdf_word_t x);
    return sdf_word_t'(0) - x;
  endfunction

  // Magnitude of a sign-extended value. For the most negative W-bit value
  // the low W bits hold 2^(W-1), which fits as an unsigned W-bit number.
  function automatic sdf_word_t sdf_abs(input sdf_word_t x);
    return x[SDF_MAX_W-1] ? sdf_neg(x) : x;
  endfunction

endpackage

// File: rtl/signed_div_frontend_sign_fix.sv
// Combinational sign restore: unsigned quotient magnitude plus sign and
// divide-by-zero flags -> signed W-bit quotient. Zero divisor forces -1.
module signed_div_frontend_sign_fix
  import signed_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q_mag,
  input  logic         sq,
  input  logic         dz,
  output logic [W-1:0] q
);

  sdf_word_t mag_ext;
  sdf_word_t neg_ext;

  // Negate in the wide word; truncation to W bits wraps MIN/-1 back to MIN.
  always_comb begin
    mag_ext = '0;
    mag_ext[W-1:0] = q_mag;
    neg_ext = sdf_neg(mag_ext);
    if (dz) begin
      q = '1;
    end else if (sq) begin
      q = neg_ext[W-1:0];
    end else begin
      q = q_mag;
    end
  end

endmodule

// File: rtl/signed_div_frontend.sv
// Signed front/back end for an unsigned restoring sequential divider.
// Optional build macro: DIVZERO_BYPASS_EN -- a zero divisor skips the
// divider and presents the -1 / dz result the cycle after acceptance.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. The frontend only asserts o_ready in IDLE and only
// asserts o_valid in DONE; o_q/o_dz are stable while o_valid is high and
// waiting for i_ready. o_div_valid is high exactly DATA_WIDTH cycles per
// operation and the divider reports completion with i_div_acc.
module signed_div_frontend
  import signed_div_pkg::*;
#(
  parameter int DATA_WIDTH = 8   // 2 .. SDF_MAX_W-1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_n,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_div_n,
  output logic [DATA_WIDTH-1:0] o_div_d,
  output logic                  o_div_valid,
  input  logic [DATA_WIDTH-1:0] i_div_q,
  input  logic                  i_div_acc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_q,
  output logic                  o_dz,
  output logic [1:0]            o_dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  sdf_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q;
  logic          sq_q, dz_q;
  logic [W-1:0]  q_q;
  logic          load, capture, d_zero, accept;
  logic [W-1:0]  q_fixed;
  sdf_word_t     n_ext, d_ext, n_abs, d_abs;

  assign accept      = i_valid & ready_q;
  assign d_zero      = (i_d == '0);
  assign o_ready     = ready_q;
  assign o_div_valid = (state_q == BUSY);
  assign o_valid     = (state_q == DONE);
  assign o_q         = q_q;
  assign o_dz        = dz_q;
  assign o_dbg_state = state_q;

  // Operand magnitudes via the wide-word helpers.
  always_comb begin
    n_ext = {{(SDF_MAX_W-W){i_n[W-1]}}, i_n};
    d_ext = {{(SDF_MAX_W-W){i_d[W-1]}}, i_d};
    n_abs = sdf_abs(n_ext);
    d_abs = sdf_abs(d_ext);
  end

  signed_div_frontend_sign_fix #(.W(W)) u_sign_fix (
    .q_mag (i_div_q),
    .sq    (sq_q),
    .dz    (dz_q),
    .q     (q_fixed)
  );

  // Next state, cycle counter and load/capture strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
`ifdef DIVZERO_BYPASS_EN
          if (d_zero) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LAST;
          end
`else
          state_d = BUSY;
          cnt_d   = CNT_LAST;
`endif
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        // Divider valid is low here so its counter stops at its reload.
        if (i_div_acc) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; o_ready is registered so it rises one cycle after reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
    end
  end

  // Operand, sign/zero flag and result registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_div_n <= '0;
      o_div_d <= '0;
      sq_q    <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
    end else begin
      if (load) begin
        o_div_n <= n_abs[W-1:0];
        o_div_d <= d_abs[W-1:0];
        sq_q    <= i_n[W-1] ^ i_d[W-1];
        dz_q    <= d_zero;
`ifdef DIVZERO_BYPASS_EN
        if (d_zero) begin
          q_q <= '1;
        end
`endif
      end
      if (capture) begin
        q_q <= q_fixed;
      end
    end
  end

endmodule

// File: tb/tb_signed_div_frontend.sv
// Bench for signed_div_frontend, W=8, with an inline behavioural model of
// the unsigned sequential divider (W valid cycles -> one accept pulse).
module tb_signed_div_frontend;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic         i_valid, o_ready, o_div_valid, div_acc, o_valid, i_ready, o_dz;
  logic [W-1:0] i_n, i_d, o_div_n, o_div_d, div_q, o_q;
  logic [1:0]   dbg_state;

  signed_div_frontend #(.DATA_WIDTH(W)) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_n         (i_n),
    .i_d         (i_d),
    .o_div_n     (o_div_n),
    .o_div_d     (o_div_d),
    .o_div_valid (o_div_valid),
    .i_div_q     (div_q),
    .i_div_acc   (div_acc),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_q         (o_q),
    .o_dz        (o_dz),
    .o_dbg_state (dbg_state)
  );

  // Divider model: after W cycles of valid, pulse accept with the quotient.
  // A zero divisor returns 0 so a missing -1 override shows up.
  int mdl_cnt;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mdl_cnt <= 0;
      div_acc <= 1'b0;
      div_q   <= '0;
    end else begin
      div_acc <= 1'b0;
      if (o_div_valid) begin
        if (mdl_cnt == W - 1) begin
          mdl_cnt <= 0;
          div_acc <= 1'b1;
          div_q   <= (o_div_d == '0) ? '0 : o_div_n / o_div_d;
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept_pair(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                             input logic [W-1:0] q_exp);
    int t;
    @(negedge clk);
    i_n = n;
    i_d = d;
    i_valid = 1'b1;
    t = 0;
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, "_ready"}, 32'(o_ready), 32'd1);
    exp_q.push_back(q_exp);
    @(posedge clk);
    #1 i_valid = 1'b0;
    i_n = '0;
    i_d = '0;
  endtask

  // Waits for the result, checks latency, divider-valid cycles, operand
  // magnitudes, quotient and dz; holds i_ready low for hold cycles first.
  task automatic collect(input string tag, input int exp_lat, input int exp_dv,
                         input logic [W-1:0] exp_mn, input logic [W-1:0] exp_md,
                         input logic exp_dz, input int hold);
    int lat, dv;
    logic [W-1:0] mn, md, q_exp, q0;
    lat = 0;
    dv  = 0;
    mn  = '0;
    md  = '0;
    q_exp = exp_q.pop_front();
    do begin
      @(negedge clk);
      lat++;
      if (o_div_valid) dv++;
      if (lat == 1) begin
        mn = o_div_n;
        md = o_div_d;
      end
    end while (!o_valid && lat < 100);
    check_val({tag, "_valid"}, 32'(o_valid), 32'd1);
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_dv"}, 32'(dv), 32'(exp_dv));
    if (exp_dv > 0) begin
      check_val({tag, "_mag"}, {16'd0, mn, md}, {16'd0, exp_mn, exp_md});
    end
    check_val({tag, "_q"}, 32'(o_q), 32'(q_exp));
    check_val({tag, "_dz"}, 32'(o_dz), 32'(exp_dz));
    if (hold > 0) begin
      q0 = o_q;
      repeat (hold) @(negedge clk);
      check_val({tag, "_hold"}, {29'd0, o_valid, o_ready, (o_q == q0)}, {29'd0, 1'b1, 1'b0, 1'b1});
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_ret"}, {30'd0, o_valid, o_ready}, {30'd0, 1'b0, 1'b1});
  endtask

`ifdef DIVZERO_BYPASS_EN
  localparam int DZ_LAT = 1;
  localparam int DZ_DV  = 0;
`else
  localparam int DZ_LAT = W + 2;
  localparam int DZ_DV  = W;
`endif

  // Directed vectors: n, d, quotient, |n|, |d|, dz
  typedef struct {
    logic [W-1:0] n, d, q, mn, md;
    logic         dz;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{n: 8'd100,  d: 8'd7,    q: 8'd14,  mn: 8'd100, md: 8'd7, dz: 1'b0};
    vecs[1] = '{n: 8'h9C,   d: 8'd7,    q: 8'hF2,  mn: 8'd100, md: 8'd7, dz: 1'b0};
    vecs[2] = '{n: 8'd100,  d: 8'hF9,   q: 8'hF2,  mn: 8'd100, md: 8'd7, dz: 1'b0};
    vecs[3] = '{n: 8'h9C,   d: 8'hF9,   q: 8'd14,  mn: 8'd100, md: 8'd7, dz: 1'b0};
    vecs[4] = '{n: 8'h80,   d: 8'hFF,   q: 8'h80,  mn: 8'h80,  md: 8'd1, dz: 1'b0};
    vecs[5] = '{n: 8'h80,   d: 8'd1,    q: 8'h80,  mn: 8'h80,  md: 8'd1, dz: 1'b0};
    vecs[6] = '{n: 8'd0,    d: 8'd5,    q: 8'd0,   mn: 8'd0,   md: 8'd5, dz: 1'b0};
    vecs[7] = '{n: 8'd5,    d: 8'd0,    q: 8'hFF,  mn: 8'd5,   md: 8'd0, dz: 1'b1};

    i_valid = 1'b0;
    i_ready = 1'b0;
    i_n = '0;
    i_d = '0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_outs", {o_ready, o_div_valid, o_valid, o_dz, o_q, o_div_n, o_div_d},
              32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);
    nrst = 1'b1;
    #1 check_val("rst_ready_low", 32'(o_ready), 32'd0);
    @(negedge clk);
    check_val("rst_ready_high", 32'(o_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      accept_pair(tag, vecs[i].n, vecs[i].d, vecs[i].q);
      collect(tag, vecs[i].dz ? DZ_LAT : W + 2, vecs[i].dz ? DZ_DV : W,
              vecs[i].mn, vecs[i].md, vecs[i].dz, 0);
    end

    // Backpressure: result held for 20 cycles, then a second pair.
    accept_pair("bp1", 8'd100, 8'd7, 8'd14);
    collect("bp1", W + 2, W, 8'd100, 8'd7, 1'b0, 20);
    accept_pair("bp2", 8'd27, 8'd3, 8'd9);
    collect("bp2", W + 2, W, 8'd27, 8'd3, 1'b0, 0);

    // Reset in the middle of BUSY.
    accept_pair("ab", 8'd100, 8'd7, 8'd14);
    repeat (4) @(negedge clk);
    check_val("ab_busy", 32'(o_div_valid), 32'd1);
    nrst = 1'b0;
    #1 check_val("ab_rst_outs", {o_ready, o_div_valid, o_valid, o_dz, o_q, o_div_n, o_div_d},
                 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    accept_pair("post", 8'd50, 8'd5, 8'd10);
    collect("post", W + 2, W, 8'd50, 8'd5, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no end expected end");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
